// File: rtl/sparc_ifu_thrsched.sv
// Per-core IFU thread scheduler: round-robin pick of a ready thread, time-slice quantum,
// and one-cycle schedule/switch_out pulses. Define IFU_THRSCHED_SPEC_EN to make SPEC_RDY eligible.
module sparc_ifu_thrsched #(
  parameter int unsigned NTHR    = 4,
  parameter int unsigned QUANTUM = 16,
  parameter int unsigned QCNT_W  = 5
) (
  input  logic            clk,
  input  logic            arst_l,
  input  logic [NTHR-1:0] thr_rdy,
  input  logic [NTHR-1:0] thr_spec_rdy,
  input  logic            run_stop,
  input  logic            switch_req,
  input  logic            fe_stall,
  output logic [NTHR-1:0] schedule,
  output logic [NTHR-1:0] switch_out,
  output logic [NTHR-1:0] run_thr,
  output logic            run_vld
);

  localparam int unsigned PTR_W = (NTHR > 1) ? $clog2(NTHR) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StSwitch} state_e;

  state_e              state_q, state_d;
  logic [NTHR-1:0]     schedule_q, schedule_d;
  logic [NTHR-1:0]     switch_out_q, switch_out_d;
  logic [NTHR-1:0]     run_thr_q, run_thr_d;
  logic                run_vld_q, run_vld_d;
  logic [QCNT_W-1:0]   qcnt_q, qcnt_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NTHR-1:0]     elig_rdy, elig_spec, win_oh;
  logic                found_rdy, found_spec, any_elig, qcnt_max;
  logic [PTR_W-1:0]    win_rdy, win_spec, win, idx, win_inc;
  int unsigned         pos;

  assign elig_rdy = thr_rdy & ~run_thr_q;
`ifdef IFU_THRSCHED_SPEC_EN
  assign elig_spec = thr_spec_rdy & ~run_thr_q;
`else
  logic unused_spec;
  assign unused_spec = ^thr_spec_rdy;
  assign elig_spec   = '0;
`endif

  // Rotating search from rr_ptr; the RDY set is searched before the SPEC_RDY set.
  always_comb begin
    found_rdy  = 1'b0;
    found_spec = 1'b0;
    win_rdy    = '0;
    win_spec   = '0;
    pos        = 0;
    idx        = '0;
    for (int unsigned i = 0; i < NTHR; i++) begin
      pos = (32'(rr_ptr_q) + i) % NTHR;
      idx = PTR_W'(pos);
      if (!found_rdy && elig_rdy[idx]) begin
        found_rdy = 1'b1;
        win_rdy   = idx;
      end
      if (!found_spec && elig_spec[idx]) begin
        found_spec = 1'b1;
        win_spec   = idx;
      end
    end
  end

  assign any_elig = found_rdy | found_spec;
  assign win      = found_rdy ? win_rdy : win_spec;
  assign win_inc  = (win == PTR_W'(NTHR - 1)) ? '0 : win + 1'b1;
  assign qcnt_max = (qcnt_q == QCNT_W'(QUANTUM - 1));

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    schedule_d   = '0;
    switch_out_d = '0;
    run_thr_d    = run_thr_q;
    run_vld_d    = run_vld_q;
    qcnt_d       = qcnt_q;
    rr_ptr_d     = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any_elig && !fe_stall) begin
          schedule_d = win_oh;
          run_thr_d  = win_oh;
          run_vld_d  = 1'b1;
          qcnt_d     = '0;
          rr_ptr_d   = win_inc;
          state_d    = StRun;
        end
      end
      StRun: begin
        // run_stop wins over switch_req/expiry and is honoured even under fe_stall.
        if (run_stop) begin
          run_thr_d = '0;
          run_vld_d = 1'b0;
          state_d   = StSwitch;
        end else if ((switch_req || (qcnt_max && any_elig)) && !fe_stall) begin
          switch_out_d = run_thr_q;
          run_thr_d    = '0;
          run_vld_d    = 1'b0;
          state_d      = StSwitch;
        end else if (!fe_stall && !qcnt_max) begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      StSwitch: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q      <= StIdle;
      schedule_q   <= '0;
      switch_out_q <= '0;
      run_thr_q    <= '0;
      run_vld_q    <= 1'b0;
      qcnt_q       <= '0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      schedule_q   <= schedule_d;
      switch_out_q <= switch_out_d;
      run_thr_q    <= run_thr_d;
      run_vld_q    <= run_vld_d;
      qcnt_q       <= qcnt_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign schedule   = schedule_q;
  assign switch_out = switch_out_q;
  assign run_thr    = run_thr_q;
  assign run_vld    = run_vld_q;

endmodule
